// File: rtl/mac_vlg_pkg.sv
// mac_vlg_pkg: shared MAC framer/deframer types, constants and the receive FSM encoding.
// Contents: mac_addr_t, fcs_t, mac_hdr_t, mac_meta_t, PREAMBLE, MAC_SFD,
//           MAC_BROADCAST, MAC_FCS_RESIDUE, mac_rx_fsm_t.
package mac_vlg_pkg;
    typedef logic [47:0] mac_addr_t;
    typedef logic [31:0] fcs_t;
    typedef struct packed {
        mac_addr_t   dst_mac;
        mac_addr_t   src_mac;
        logic [15:0] ethertype;
    } mac_hdr_t;
    typedef struct packed {
        mac_hdr_t    hdr;
        logic [15:0] length;
        logic        val;
    } mac_meta_t;
    localparam logic [7:0] PREAMBLE        = 8'h55;
    localparam logic [7:0] MAC_SFD         = 8'hD5;
    localparam mac_addr_t  MAC_BROADCAST   = 48'hFFFF_FFFF_FFFF;
    localparam fcs_t       MAC_FCS_RESIDUE = 32'hDEBB20E3;
    typedef enum logic [2:0] {RX_DROP, RX_IDLE, RX_PRE, RX_HDR, RX_PLD} mac_rx_fsm_t;
endpackage

// File: rtl/mac_vlg_crc32_byte.sv
// mac_vlg_crc32_byte: byte-wide reflected CRC-32 (poly 0x04C11DB7, no final xor) with state register.
// Ports: clk, rst_n (sync, active-low), init (load 0xFFFFFFFF), en (absorb dat), dat[7:0], crc[31:0] (register).
import mac_vlg_pkg::*;
module mac_vlg_crc32_byte (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] dat,
    output fcs_t       crc
);
    fcs_t crc_q, crc_d;
    function automatic fcs_t crc_step(input fcs_t c, input logic [7:0] d);
        fcs_t r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction
    always_comb crc_d = init ? '1 : en ? crc_step(crc_q, dat) : crc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end
    assign crc = crc_q;
endmodule

// File: rtl/mac_vlg_rx_deframer.sv
// mac_vlg_rx_deframer: GMII-style receive deframer; checks preamble/SFD, parses and filters the
// header, strips the FCS and emits payload bytes with sof/eof framing and a meta descriptor.
// Ports: clk, rst_n (sync, active-low); phy_dat/phy_val/phy_err (PHY byte stream);
//        rx_dat/rx_val/rx_sof/rx_eof/rx_err, rx_meta (registered payload stream + descriptor).
// Option: define MAC_RX_FCS_CHECK_EN to add a CRC-32 residue check that sets rx_err at eof.
import mac_vlg_pkg::*;
module mac_vlg_rx_deframer #(
    parameter mac_addr_t MAC_ADDR    = 48'h02_00_00_00_00_01,
    parameter int        PROMISC     = 0,
    parameter int        MAX_PAYLOAD = 1500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] phy_dat,
    input  logic       phy_val,
    input  logic       phy_err,
    output logic [7:0] rx_dat,
    output logic       rx_val,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_err,
    output mac_meta_t  rx_meta
);
    mac_rx_fsm_t  state_q, state_d;
    logic [3:0]   pre_cnt_q, pre_cnt_d, hdr_cnt_q, hdr_cnt_d;
    mac_hdr_t     hdr_q, hdr_d;
    logic [39:0]  dly_q, dly_d;
    logic [2:0]   dly_cnt_q, dly_cnt_d;
    logic [15:0]  len_q, len_d;
    logic         bad_q, bad_d;
    logic [7:0]   rx_dat_q, rx_dat_d;
    logic         rx_val_q, rx_val_d, rx_sof_q, rx_sof_d, rx_eof_q, rx_eof_d, rx_err_q, rx_err_d;
    mac_meta_t    meta_q, meta_d;
    logic [111:0] hdr_shift;
    logic         pass, emit, last, last_err, fcs_bad;
`ifdef MAC_RX_FCS_CHECK_EN
    fcs_t crc;
    mac_vlg_crc32_byte u_crc (
        .clk  (clk),
        .rst_n(rst_n),
        .init (state_q == RX_PRE && phy_val && phy_dat == MAC_SFD),
        .en   (phy_val && (state_q == RX_HDR || state_q == RX_PLD)),
        .dat  (phy_dat),
        .crc  (crc)
    );
    assign fcs_bad = crc != MAC_FCS_RESIDUE;
`else
    assign fcs_bad = 1'b0;
`endif
    assign hdr_shift = {hdr_q[103:0], phy_dat};
    assign pass = PROMISC != 0 || hdr_shift[111:64] == MAC_ADDR || hdr_shift[111:64] == MAC_BROADCAST;
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_d     = hdr_q;
        dly_d     = dly_q;
        dly_cnt_d = dly_cnt_q;
        len_d     = len_q;
        bad_d     = bad_q | (phy_val & phy_err);
        emit      = 1'b0;
        last      = 1'b0;
        last_err  = 1'b0;
        rx_dat_d  = rx_dat_q;
        rx_val_d  = 1'b0;
        rx_sof_d  = 1'b0;
        rx_eof_d  = 1'b0;
        rx_err_d  = 1'b0;
        meta_d    = meta_q;
        meta_d.val = 1'b0;
        case (state_q)
            RX_DROP: if (!phy_val) state_d = RX_IDLE;
            RX_IDLE: if (phy_val) begin
                state_d   = phy_dat == PREAMBLE ? RX_PRE : RX_DROP;
                pre_cnt_d = 4'd1;
            end
            RX_PRE: begin
                if (!phy_val) state_d = RX_IDLE;
                else if (phy_dat == PREAMBLE) begin
                    pre_cnt_d = pre_cnt_q + 4'd1;
                    if (pre_cnt_q == 4'd7) state_d = RX_DROP;
                end else if (phy_dat == MAC_SFD) begin
                    state_d   = RX_HDR;
                    hdr_cnt_d = '0;
                    bad_d     = phy_err;
                end else state_d = RX_DROP;
            end
            RX_HDR: begin
                if (!phy_val) state_d = RX_IDLE;
                else begin
                    hdr_d     = hdr_shift;
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd13) begin
                        state_d   = pass ? RX_PLD : RX_DROP;
                        dly_cnt_d = '0;
                        len_d     = '0;
                    end
                end
            end
            RX_PLD: begin
                if (!phy_val) begin
                    // Fewer than five post-header bytes is a runt: nothing was emitted, nothing to close.
                    state_d  = RX_IDLE;
                    emit     = dly_cnt_q == 3'd5;
                    last     = 1'b1;
                    last_err = bad_q | fcs_bad;
                end else begin
                    dly_d = {dly_q[31:0], phy_dat};
                    if (dly_cnt_q != 3'd5) dly_cnt_d = dly_cnt_q + 3'd1;
                    else begin
                        emit = 1'b1;
                        if (len_q == 16'(MAX_PAYLOAD - 1)) begin
                            last     = 1'b1;
                            last_err = 1'b1;
                            state_d  = RX_DROP;
                        end
                    end
                end
            end
            default: state_d = RX_DROP;
        endcase
        if (emit) begin
            rx_val_d      = 1'b1;
            rx_dat_d      = dly_q[39:32];
            rx_sof_d      = len_q == '0;
            rx_eof_d      = last;
            rx_err_d      = last & last_err;
            len_d         = len_q + 16'd1;
            meta_d.length = len_q + 16'd1;
            meta_d.val    = last;
            if (len_q == '0) meta_d.hdr = hdr_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RX_DROP;
            pre_cnt_q <= '0;
            hdr_cnt_q <= '0;
            hdr_q     <= '0;
            dly_q     <= '0;
            dly_cnt_q <= '0;
            len_q     <= '0;
            bad_q     <= 1'b0;
            rx_dat_q  <= '0;
            rx_val_q  <= 1'b0;
            rx_sof_q  <= 1'b0;
            rx_eof_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            meta_q    <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            hdr_cnt_q <= hdr_cnt_d;
            hdr_q     <= hdr_d;
            dly_q     <= dly_d;
            dly_cnt_q <= dly_cnt_d;
            len_q     <= len_d;
            bad_q     <= bad_d;
            rx_dat_q  <= rx_dat_d;
            rx_val_q  <= rx_val_d;
            rx_sof_q  <= rx_sof_d;
            rx_eof_q  <= rx_eof_d;
            rx_err_q  <= rx_err_d;
            meta_q    <= meta_d;
        end
    end
    assign rx_dat  = rx_dat_q;
    assign rx_val  = rx_val_q;
    assign rx_sof  = rx_sof_q;
    assign rx_eof  = rx_eof_q;
    assign rx_err  = rx_err_q;
    assign rx_meta = meta_q;
endmodule
